// File: rtl/regfile_write_arbiter_pkg.sv
// Shared CPU definitions for the register-file write path.
// Holds the GPR geometry, the default debug starvation limit, and the
// types used between the arbiter, its write register and the scoreboard.
package regfile_write_arbiter_pkg;

    localparam int NUM_GPR            = 8;
    localparam int IDX_W              = 3;
    localparam int DATA_W             = 16;
    localparam int STARVE_W           = 3;
    localparam int DBG_STARVE_MAX_DEF = 4;

    typedef logic [IDX_W-1:0]  gpr_idx_t;
    typedef logic [DATA_W-1:0] gpr_data_t;

    // Registered register-file write port.
    typedef struct packed {
        logic      en;
        gpr_idx_t  idx;
        gpr_data_t data;
    } wr_req_t;

    // Source that won arbitration this cycle.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_LD,
        SRC_EX,
        SRC_DBG
    } wr_src_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// GPR pending-write scoreboard.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   set_en, set_idx     mark a GPR as having a write in flight (issue)
//   clr_en, clr_idx     retire a GPR's pending write (ld/ex writeback)
//   flush               drop every pending bit and ignore this cycle's set
//   rd_src_idx/dst_idx  decode operand indices, rd_rc selects constant bank
//   pending             one bit per GPR
//   hz_src, hz_dst      operand hazards, only meaningful for the GPR bank
module regfile_scoreboard
    import regfile_write_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               set_en,
    input  logic [IDX_W-1:0]   set_idx,
    input  logic               clr_en,
    input  logic [IDX_W-1:0]   clr_idx,
    input  logic               flush,
    input  logic [IDX_W-1:0]   rd_src_idx,
    input  logic [IDX_W-1:0]   rd_dst_idx,
    input  logic               rd_rc,
    output logic [NUM_GPR-1:0] pending,
    output logic               hz_src,
    output logic               hz_dst
);

    logic [NUM_GPR-1:0] set_mask, clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_idx] = 1'b1;
        if (clr_en) clr_mask[clr_idx] = 1'b1;
    end

    // Set is applied after clear so a same-cycle issue to the register being
    // retired keeps it pending (the new instruction still owes a write).
    always_ff @(posedge clk) begin
        if (!rst_n || flush) pending <= '0;
        else                 pending <= (pending & ~clr_mask) | set_mask;
    end

    assign hz_src = pending[rd_src_idx] & ~rd_rc;
    assign hz_dst = pending[rd_dst_idx] & ~rd_rc;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter.
// Three writers (load writeback, ALU writeback, debug loader) share the single
// GPR write port. Priority is ld > ex > dbg, except that debug is forced
// through after DBG_STARVE_MAX consecutive denied cycles. The winner is
// registered onto wr_en/wr_idx/wr_data one cycle later. A scoreboard tracks
// GPRs with writes in flight for decode hazard detection.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   ld_*/ex_*/dbg_*                 valid/idx/data requests, ready = granted
//   iss_valid, iss_dst              issue of a GPR-writing instruction
//   flush                           pipeline flush
//   rd_src_idx, rd_dst_idx, rd_rc   decode operand lookup
//   hz_src, hz_dst                  operand hazards
//   wr_en, wr_idx, wr_data          registered register-file write port
//   pending                         scoreboard contents
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DBG_STARVE_MAX = DBG_STARVE_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ld_valid,
    input  logic [IDX_W-1:0]   ld_idx,
    input  logic [DATA_W-1:0]  ld_data,
    output logic               ld_ready,
    input  logic               ex_valid,
    input  logic [IDX_W-1:0]   ex_idx,
    input  logic [DATA_W-1:0]  ex_data,
    output logic               ex_ready,
    input  logic               dbg_valid,
    input  logic [IDX_W-1:0]   dbg_idx,
    input  logic [DATA_W-1:0]  dbg_data,
    output logic               dbg_ready,
    input  logic               iss_valid,
    input  logic [IDX_W-1:0]   iss_dst,
    input  logic               flush,
    input  logic [IDX_W-1:0]   rd_src_idx,
    input  logic [IDX_W-1:0]   rd_dst_idx,
    input  logic               rd_rc,
    output logic               hz_src,
    output logic               hz_dst,
    output logic               wr_en,
    output logic [IDX_W-1:0]   wr_idx,
    output logic [DATA_W-1:0]  wr_data,
    output logic [NUM_GPR-1:0] pending
);

    logic [STARVE_W-1:0] starve_cnt;
    logic                dbg_force;
    wr_src_e             gnt_src;
    wr_req_t             wr_d, wr_q;

    // Compared at int width so a limit beyond the counter range never forces.
    assign dbg_force = dbg_valid && (int'(starve_cnt) == DBG_STARVE_MAX);

    // Readies are gated by rst_n so nothing is granted while in reset.
    // ex is squashed on flush: the flushed instruction must not retire.
    always_comb begin
        gnt_src = SRC_NONE;
        if (rst_n) begin
            if (dbg_force)             gnt_src = SRC_DBG;
            else if (ld_valid)         gnt_src = SRC_LD;
            else if (ex_valid && !flush) gnt_src = SRC_EX;
            else if (dbg_valid)        gnt_src = SRC_DBG;
        end
    end

    assign ld_ready  = (gnt_src == SRC_LD);
    assign ex_ready  = (gnt_src == SRC_EX);
    assign dbg_ready = (gnt_src == SRC_DBG);

    // idx/data hold their last value when idle; only wr_en drops.
    always_comb begin
        wr_d    = wr_q;
        wr_d.en = 1'b0;
        case (gnt_src)
            SRC_LD:  wr_d = '{en: 1'b1, idx: ld_idx,  data: ld_data};
            SRC_EX:  wr_d = '{en: 1'b1, idx: ex_idx,  data: ex_data};
            SRC_DBG: wr_d = '{en: 1'b1, idx: dbg_idx, data: dbg_data};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) wr_q <= '0;
        else        wr_q <= wr_d;
    end

    assign wr_en   = wr_q.en;
    assign wr_idx  = wr_q.idx;
    assign wr_data = wr_q.data;

    // Saturating count of consecutive cycles debug waited and lost.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            starve_cnt <= '0;
        end else if (dbg_valid && !dbg_ready) begin
            if (starve_cnt != '1) starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end

    // Only architectural writebacks retire scoreboard entries; debug writes
    // are outside the instruction stream.
    regfile_scoreboard u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en     (iss_valid),
        .set_idx    (iss_dst),
        .clr_en     (ld_ready | ex_ready),
        .clr_idx    (ld_ready ? ld_idx : ex_idx),
        .flush      (flush),
        .rd_src_idx (rd_src_idx),
        .rd_dst_idx (rd_dst_idx),
        .rd_rc      (rd_rc),
        .pending    (pending),
        .hz_src     (hz_src),
        .hz_dst     (hz_dst)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ld_valid, ex_valid, dbg_valid, iss_valid, flush, rd_rc;
    logic [IDX_W-1:0]  ld_idx, ex_idx, dbg_idx, iss_dst, rd_src_idx, rd_dst_idx;
    logic [DATA_W-1:0] ld_data, ex_data, dbg_data;
    logic              ld_ready, ex_ready, dbg_ready, hz_src, hz_dst, wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [NUM_GPR-1:0] pending;

    regfile_write_arbiter #(.DBG_STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_data(ld_data), .ld_ready(ld_ready),
        .ex_valid(ex_valid), .ex_idx(ex_idx), .ex_data(ex_data), .ex_ready(ex_ready),
        .dbg_valid(dbg_valid), .dbg_idx(dbg_idx), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
        .iss_valid(iss_valid), .iss_dst(iss_dst), .flush(flush),
        .rd_src_idx(rd_src_idx), .rd_dst_idx(rd_dst_idx), .rd_rc(rd_rc),
        .hz_src(hz_src), .hz_dst(hz_dst),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .pending(pending)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: pending set as a plain bit array, starvation as int.
    logic [7:0]  m_pend = '0;
    int          m_starve = 0;
    logic [18:0] exp_q[$];   // {idx, data} of writes expected on the port

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever the DUT presents a write, pop and compare.
    always @(posedge clk) begin
        #2;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", {31'd0, wr_en}, 32'd0);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                chk("wr_idx", {29'd0, wr_idx}, {29'd0, e[18:16]});
                chk("wr_data", {16'd0, wr_data}, {16'd0, e[15:0]});
            end
        end
    end

    // One clock cycle: inputs already driven. Returns grant (0 none,1 ld,2 ex,3 dbg).
    task automatic step(output int g);
        logic [7:0] nxt;
        #1;
        g = 0;
        if (rst_n) begin
            if (dbg_valid && m_starve == 4) g = 3;
            else if (ld_valid)              g = 1;
            else if (ex_valid && !flush)    g = 2;
            else if (dbg_valid)             g = 3;
        end
        chk("ld_ready",  {31'd0, ld_ready},  {31'd0, g == 1});
        chk("ex_ready",  {31'd0, ex_ready},  {31'd0, g == 2});
        chk("dbg_ready", {31'd0, dbg_ready}, {31'd0, g == 3});
        chk("hz_src", {31'd0, hz_src}, {31'd0, m_pend[rd_src_idx] & ~rd_rc});
        chk("hz_dst", {31'd0, hz_dst}, {31'd0, m_pend[rd_dst_idx] & ~rd_rc});
        if (g == 1) exp_q.push_back({ld_idx, ld_data});
        if (g == 2) exp_q.push_back({ex_idx, ex_data});
        if (g == 3) exp_q.push_back({dbg_idx, dbg_data});
        nxt = m_pend;
        if (!rst_n || flush) nxt = '0;
        else begin
            if (g == 1) nxt[ld_idx] = 1'b0;
            if (g == 2) nxt[ex_idx] = 1'b0;
            if (iss_valid) nxt[iss_dst] = 1'b1;
        end
        @(posedge clk);
        m_pend = nxt;
        if (!rst_n || flush)         m_starve = 0;
        else if (dbg_valid && g != 3) m_starve = (m_starve < 7) ? m_starve + 1 : 7;
        else                         m_starve = 0;
        @(negedge clk);
        chk("pending", {24'd0, pending}, {24'd0, m_pend});
        chk("wr_missing", exp_q.size(), 0);
    endtask

    task automatic idle();
        ld_valid = 0; ex_valid = 0; dbg_valid = 0; iss_valid = 0; flush = 0; rd_rc = 0;
        ld_idx = 0; ex_idx = 0; dbg_idx = 0; iss_dst = 0; rd_src_idx = 0; rd_dst_idx = 0;
        ld_data = 0; ex_data = 0; dbg_data = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int dbg_at;
        idle();
        rst_n = 0;
        @(posedge clk);
        @(negedge clk);
        step(g);
        step(g);
        chk("rst_wr_en",   {31'd0, wr_en}, 32'd0);
        chk("rst_wr_idx",  {29'd0, wr_idx}, 32'd0);
        chk("rst_wr_data", {16'd0, wr_data}, 32'd0);
        chk("rst_pending", {24'd0, pending}, 32'd0);
        rst_n = 1;

        // ld beats ex
        ld_valid = 1; ld_idx = 2; ld_data = 16'hA5A5;
        ex_valid = 1; ex_idx = 5; ex_data = 16'h1234;
        step(g);
        chk("prio_ld_grant", g, 1);
        chk("prio_wr_idx", {29'd0, wr_idx}, 32'd2);
        chk("prio_wr_data", {16'd0, wr_data}, 32'hA5A5);
        idle();
        step(g);

        // debug starvation against a continuously valid ex
        dbg_at = 0;
        ex_valid = 1; ex_idx = 1; ex_data = 16'h0E0E;
        dbg_valid = 1; dbg_idx = 6; dbg_data = 16'hDB60;
        for (int c = 1; c <= 5; c++) begin
            step(g);
            if (g == 3 && dbg_at == 0) dbg_at = c;
        end
        chk("starve_dbg_cycle", dbg_at, 5);
        dbg_idx = 7; dbg_data = 16'hDB70;
        step(g);
        chk("starve_reset_deny", g, 2);
        idle();
        step(g);

        // hazard lookup
        iss_valid = 1; iss_dst = 3;
        step(g);
        chk("iss_pending", {24'd0, pending}, 32'h08);
        idle();
        rd_src_idx = 3; rd_rc = 0;
        #1 chk("hz_src_gpr", {31'd0, hz_src}, 32'd1);
        rd_rc = 1;
        #1 chk("hz_src_const", {31'd0, hz_src}, 32'd0);
        step(g);

        // same-cycle clear and set keeps bit
        ex_valid = 1; ex_idx = 3; ex_data = 16'h3333; iss_valid = 1; iss_dst = 3;
        step(g);
        chk("set_clr_same", {31'd0, pending[3]}, 32'd1);
        idle();

        // flush with everything pending
        for (int r = 0; r < 8; r++) begin
            iss_valid = 1; iss_dst = 3'(r);
            step(g);
        end
        idle();
        chk("all_pending", {24'd0, pending}, 32'hFF);
        flush = 1; ex_valid = 1; ex_idx = 4; ex_data = 16'h4444;
        step(g);
        chk("flush_ex_ready", g, 0);
        chk("flush_pending", {24'd0, pending}, 32'h00);
        idle();

        // reset mid-stream with a write in flight
        for (int r = 0; r < 4; r++) begin
            iss_valid = 1; iss_dst = 3'(r);
            step(g);
        end
        idle();
        chk("pend_0f", {24'd0, pending}, 32'h0F);
        ld_valid = 1; ld_idx = 6; ld_data = 16'h6666;
        step(g);
        rst_n = 0; ld_idx = 7; ld_data = 16'h7777;
        step(g);
        chk("rst_mid_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_mid_pending", {24'd0, pending}, 32'd0);
        rst_n = 1;
        idle();
        step(g);

        // randomized traffic; requesters hold until granted
        g = 0;
        for (int i = 0; i < 1500; i++) begin
            if (g == 1 || !rst_n) ld_valid = 0;
            if (g == 2 || !rst_n) ex_valid = 0;
            if (g == 3 || !rst_n) dbg_valid = 0;
            if (!ld_valid) begin
                ld_valid = ($urandom % 3 == 0); ld_idx = 3'($urandom); ld_data = 16'($urandom);
            end
            if (!ex_valid) begin
                ex_valid = ($urandom % 2 == 0); ex_idx = 3'($urandom); ex_data = 16'($urandom);
            end
            if (!dbg_valid) begin
                dbg_valid = ($urandom % 4 == 0); dbg_idx = 3'($urandom); dbg_data = 16'($urandom);
            end
            iss_valid = ($urandom % 2 == 0); iss_dst = 3'($urandom);
            flush = ($urandom % 20 == 0);
            rst_n = ($urandom % 100 != 0);
            rd_src_idx = 3'($urandom); rd_dst_idx = 3'($urandom); rd_rc = ($urandom % 4 == 0);
            step(g);
        end
        rst_n = 1;
        idle();
        step(g);
        step(g);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have one parameter: DBG_STARVE_MAX, default 4, the number of consecutive denied debug cycles before debug is forced.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock; all state updates on rising edge
  rst_n  in  1  synchronous, active-low reset
  ld_valid  in  1  memory-stage load writeback request
  ld_idx  in  3  load target GPR (bank 0)
  ld_data  in  16  load writeback data
  ld_ready  out  1  load request granted this cycle
  ex_valid  in  1  execute-stage ALU writeback request
  ex_idx  in  3  ALU target GPR
  ex_data  in  16  ALU result
  ex_ready  out  1  ALU request granted this cycle
  dbg_valid  in  1  debug/loader write request
  dbg_idx  in  3  debug target GPR
  dbg_data  in  16  debug write data
  dbg_ready  out  1  debug request granted this cycle
  iss_valid  in  1  decode issues an instruction that writes a GPR
  iss_dst  in  3  destination GPR of issued instruction
  flush  in  1  pipeline flush
  rd_src_idx  in  3  decode source operand index
  rd_dst_idx  in  3  decode destination operand index
  rd_rc  in  1  operand bank select (0 = GPR, 1 = constant)
  hz_src  out  1  source operand has pending write
  hz_dst  out  1  destination operand has pending write
  wr_en  out  1  register file write enable (bank 0 only)
  wr_idx  out  3  register file write index
  wr_data  out  16  register file write data
  pending  out  8  scoreboard, one bit per GPR

Function
REQ-003 Arbitration SHALL be combinational on the current cycle: at most one of ld_ready, ex_ready, dbg_ready is 1; a ready is 1 only when its valid is 1.
REQ-004 Normal priority SHALL be ld > ex > dbg (older instruction first).
REQ-005 A 3-bit saturating starve counter SHALL increment each cycle dbg_valid=1 and dbg_ready=0, and clear to 0 when dbg_ready=1 or dbg_valid=0.
REQ-006 When starve counter equals DBG_STARVE_MAX and dbg_valid=1, dbg SHALL win over ld and ex for that cycle.
REQ-007 A granted request SHALL appear on wr_en/wr_idx/wr_data on the next clock edge (1-cycle latency, registered outputs); wr_en=0 in cycles following no grant.
REQ-008 Requesters SHALL hold valid/idx/data stable until ready; the block does not buffer ungranted requests.
REQ-009 Scoreboard: iss_valid=1 sets pending[iss_dst]; an ld or ex grant clears pending[granted idx]; debug grants SHALL NOT change pending.
REQ-010 Simultaneous set and clear of the same bit SHALL leave it set.
REQ-011 flush=1 SHALL clear all pending bits, suppress ex_ready that cycle, suppress the iss_valid set, and clear the starve counter; ld and dbg arbitrate normally.
REQ-012 hz_src SHALL be pending[rd_src_idx] & ~rd_rc and hz_dst SHALL be pending[rd_dst_idx] & ~rd_rc, combinational from the registered pending.

Reset
REQ-013 When rst_n=0 at a clock edge: pending=0, starve counter=0, wr_en=0, wr_idx=0, wr_data=0; readies SHALL be 0 while rst_n=0.
REQ-014 A write granted in the cycle before reset SHALL be dropped if reset is asserted at the edge that would output it.

Structure
REQ-015 GPR count (8), index width (3), data width (16) and DBG_STARVE_MAX default SHALL live in the shared CPU package.
REQ-016 The scoreboard SHALL be a sub-module named regfile_scoreboard; the arbiter and write register remain in the top.

Verification
REQ-017 ld and ex both valid, ld_idx=2, ex_idx=5 -> ld_ready=1, ex_ready=0; next cycle wr_en=1, wr_idx=2, wr_data=ld_data.
REQ-018 dbg_valid held with ex_valid held for 5 cycles -> dbg_ready=0 for 4 cycles, then dbg_ready=1 in cycle 5; counter returns to 0.
REQ-019 iss_valid, iss_dst=3 -> pending=0x08; rd_src_idx=3, rd_rc=0 -> hz_src=1; rd_rc=1 -> hz_src=0.
REQ-020 ex grant idx=3 with iss_valid iss_dst=3 same cycle -> pending[3] stays 1.
REQ-021 pending=0xFF, flush=1 with ex_valid=1 -> ex_ready=0, pending=0x00 next cycle.
REQ-022 rst_n=0 mid-stream with pending=0x0F and a grant outstanding -> wr_en=0, pending=0x00 after the edge.
